// File: rtl/spi_regbank_slave.sv
// SPI mode-3 slave to register-bank strobes; write strobe 1 clk after the last data bit is synchronised, readback 2 clks after the header.
// No backpressure: the bank must accept every strobe and return read data exactly one cycle after o_reg_rd_en.
module spi_regbank_slave #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int BURST_EN    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sck,
    input  logic              i_ss_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_reg_wr_en,
    output logic              o_reg_rd_en,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [DATA_W-1:0] o_reg_wdata,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic              o_frame_err,
    output logic              o_busy
);
    localparam int SHR_W = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int CW    = $clog2(SHR_W + 1);
    localparam logic [CW-1:0] HDR_LAST = CW'(ADDR_W);
    localparam logic [CW-1:0] DAT_LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_WDATA, S_RDATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q, ss_prev_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SHR_W-1:0]       shift_q, shift_d;
    logic [DATA_W-1:0]      tx_q, tx_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   first_q, first_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rd_en_q, rd_en_d;
    logic                   cap_q, cap_d;
    logic                   ferr_q, ferr_d;

    logic              sck_s, ss_s, mosi_s;
    logic              sck_rise, sck_fall, ss_fall, ss_rise;
    logic [ADDR_W:0]   hdr;
    logic [DATA_W-1:0] word;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign ss_s     = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ss_fall  = ~ss_s & ss_prev_q;
    assign ss_rise  = ss_s & ~ss_prev_q;
    assign hdr      = {shift_q[ADDR_W-1:0], mosi_s};
    assign word     = {shift_q[DATA_W-2:0], mosi_s};

    // SS_n chain resets low so a select held low across reset is not seen as a new frame
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_sync_q  <= '1;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b1;
            ss_prev_q   <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            first_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            cap_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sck_sync_q  <= (sck_sync_q << 1) | SYNC_STAGES'(i_sck);
            ss_sync_q   <= (ss_sync_q << 1) | SYNC_STAGES'(i_ss_n);
            mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(i_spi_mosi);
            sck_prev_q  <= sck_s;
            ss_prev_q   <= ss_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            first_q     <= first_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            cap_q       <= cap_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        first_d = first_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        cap_d   = rd_en_q;
        ferr_d  = 1'b0;

        // Address advances only after the strobe cycle so it stays stable while the strobe is high
        if ((wr_en_q || rd_en_q) && BURST_EN != 0)
            addr_d = addr_q + 1'b1;

        if (state_q != S_IDLE && ss_rise) begin
            state_d = S_IDLE;
            ferr_d  = (cnt_q != '0);
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ss_fall) begin
                        state_d = S_HDR;
                        cnt_d   = '0;
                        first_d = 1'b1;
                        tx_d    = '0;
                    end
                end
                S_HDR: begin
                    if (sck_rise) begin
                        shift_d = {shift_q[SHR_W-2:0], mosi_s};
                        if (cnt_q == HDR_LAST) begin
                            cnt_d  = '0;
                            addr_d = hdr[ADDR_W-1:0];
                            if (hdr[ADDR_W]) begin
                                state_d = S_WDATA;
                            end else begin
                                state_d = S_RDATA;
                                rd_en_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_WDATA: begin
                    if (sck_rise) begin
                        shift_d = {shift_q[SHR_W-2:0], mosi_s};
                        if (cnt_q == DAT_LAST) begin
                            cnt_d   = '0;
                            first_d = 1'b0;
                            if (first_q || BURST_EN != 0) begin
                                wr_en_d = 1'b1;
                                wdata_d = word;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_RDATA: begin
                    if (sck_rise) begin
                        if (cnt_q == DAT_LAST) begin
                            cnt_d   = '0;
                            first_d = 1'b0;
                            rd_en_d = (BURST_EN != 0);
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // The falling edge ahead of a word's first bit must not shift: the MSB is already on MISO
                    if (sck_fall && cnt_q != '0)
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (cap_q)
            tx_d = i_reg_rdata;
    end

    assign o_spi_miso  = (state_q == S_RDATA) && !ss_s && tx_q[DATA_W-1];
    assign o_reg_wr_en = wr_en_q;
    assign o_reg_rd_en = rd_en_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench for spi_regbank_slave: default instance plus a 4-bit address / 32-bit data / no-burst instance.
`timescale 1ns/1ps
module tb_spi_regbank_slave;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b1;
    logic ss_a = 1'b1;
    logic ss_b = 1'b1;
    logic mosi = 1'b0;
    logic cur_sel = 1'b0;

    logic       a_miso, a_wr, a_rd, a_ferr, a_busy;
    logic [6:0] a_addr;
    logic [7:0] a_wdata;
    logic [7:0] a_rdata = 8'hEE;
    logic        b_miso, b_wr, b_rd, b_ferr, b_busy;
    logic [3:0]  b_addr;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata = 32'hEEEEEEEE;

    int errors = 0;
    int checks = 0;

    int         wr_n = 0, rd_n = 0, ferr_n = 0, both_n = 0;
    logic [6:0] wr_addr [0:31];
    logic [7:0] wr_data [0:31];
    logic [6:0] rd_addr [0:31];
    int          b_wr_n = 0, b_rd_n = 0, b_ferr_n = 0;
    logic [3:0]  b_wr_addr [0:7];
    logic [31:0] b_wr_data [0:7];

    always #5 clk = ~clk;

    spi_regbank_slave dut (
        .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_ss_n(ss_a), .i_spi_mosi(mosi),
        .o_spi_miso(a_miso), .o_reg_wr_en(a_wr), .o_reg_rd_en(a_rd), .o_reg_addr(a_addr),
        .o_reg_wdata(a_wdata), .i_reg_rdata(a_rdata), .o_frame_err(a_ferr), .o_busy(a_busy)
    );

    spi_regbank_slave #(.ADDR_W(4), .DATA_W(32), .BURST_EN(0), .SYNC_STAGES(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_ss_n(ss_b), .i_spi_mosi(mosi),
        .o_spi_miso(b_miso), .o_reg_wr_en(b_wr), .o_reg_rd_en(b_rd), .o_reg_addr(b_addr),
        .o_reg_wdata(b_wdata), .i_reg_rdata(b_rdata), .o_frame_err(b_ferr), .o_busy(b_busy)
    );

    // Register bank: data only valid the cycle after a read request, filler otherwise
    always @(posedge clk) begin
        a_rdata <= a_rd ? ({1'b0, a_addr} ^ 8'h39) : 8'hEE;
        b_rdata <= b_rd ? 32'h0BAD_F00D : 32'hEEEEEEEE;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (a_wr) begin
                wr_addr[wr_n[4:0]] <= a_addr;
                wr_data[wr_n[4:0]] <= a_wdata;
                wr_n <= wr_n + 1;
            end
            if (a_rd) begin
                rd_addr[rd_n[4:0]] <= a_addr;
                rd_n <= rd_n + 1;
            end
            if (a_ferr) ferr_n <= ferr_n + 1;
            if ((a_wr && a_rd) || (b_wr && b_rd)) both_n <= both_n + 1;
            if (b_wr) begin
                b_wr_addr[b_wr_n[2:0]] <= b_addr;
                b_wr_data[b_wr_n[2:0]] <= b_wdata;
                b_wr_n <= b_wr_n + 1;
            end
            if (b_rd) b_rd_n <= b_rd_n + 1;
            if (b_ferr) b_ferr_n <= b_ferr_n + 1;
        end
    end

    task automatic spi_begin(input logic sel);
        cur_sel = sel;
        if (sel) ss_b = 1'b0; else ss_a = 1'b0;
        #(HALF);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        sck  = 1'b0;
        mosi = b;
        #(HALF);
        sck = 1'b1;
        m   = cur_sel ? b_miso : a_miso;
        #(HALF);
    endtask

    task automatic spi_end();
        ss_a = 1'b1;
        ss_b = 1'b1;
        #(4 * HALF);
    endtask

    task automatic spi_xfer(input logic sel, input int n, input logic [127:0] d, output logic [127:0] r);
        logic m;
        r = '0;
        spi_begin(sel);
        for (int i = 0; i < n; i++) begin
            spi_bit(d[n - 1 - i], m);
            r = {r[126:0], m};
        end
        spi_end();
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if ({a_wr, a_rd, a_ferr, a_busy, a_miso, a_addr, a_wdata} !== 20'h0) begin
            errors++;
            $display("FAIL reset_held_a: got %h expected 0", {a_wr, a_rd, a_ferr, a_busy, a_miso, a_addr, a_wdata});
        end
        checks++;
        if ({b_wr, b_rd, b_ferr, b_busy, b_miso, b_addr, b_wdata} !== 41'h0) begin
            errors++;
            $display("FAIL reset_held_b: got %h expected 0", {b_wr, b_rd, b_ferr, b_busy, b_miso, b_addr, b_wdata});
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({a_wr, a_rd, a_ferr, a_busy, a_miso} !== 5'h0) begin
            errors++;
            $display("FAIL reset_released_a: got %b expected 00000", {a_wr, a_rd, a_ferr, a_busy, a_miso});
        end
    endtask

    task automatic test_write();
        logic [127:0] r;
        int w0 = wr_n, f0 = ferr_n;
        spi_xfer(1'b0, 16, {1'b1, 7'h12, 8'hA5}, r);
        checks++;
        if (wr_n - w0 !== 1) begin errors++; $display("FAIL write_count: got %0d expected 1", wr_n - w0); end
        checks++;
        if (wr_addr[w0] !== 7'h12) begin errors++; $display("FAIL write_addr: got %h expected 12", wr_addr[w0]); end
        checks++;
        if (wr_data[w0] !== 8'hA5) begin errors++; $display("FAIL write_data: got %h expected a5", wr_data[w0]); end
        checks++;
        if (ferr_n - f0 !== 0) begin errors++; $display("FAIL write_no_ferr: got %0d expected 0", ferr_n - f0); end
    endtask

    task automatic test_read();
        logic [127:0] r;
        int r0 = rd_n, w0 = wr_n, n5 = 0;
        spi_xfer(1'b0, 24, {1'b0, 7'h05, 16'h0000}, r);
        checks++;
        if (r[23:16] !== 8'h00) begin errors++; $display("FAIL read_hdr_miso: got %h expected 00", r[23:16]); end
        checks++;
        if (r[15:8] !== 8'h3C) begin errors++; $display("FAIL read_word0: got %h expected 3c", r[15:8]); end
        checks++;
        if (r[7:0] !== 8'h3F) begin errors++; $display("FAIL read_word1_burst: got %h expected 3f", r[7:0]); end
        checks++;
        if (rd_addr[r0] !== 7'h05) begin errors++; $display("FAIL read_addr0: got %h expected 05", rd_addr[r0]); end
        checks++;
        if (rd_addr[r0 + 1] !== 7'h06) begin errors++; $display("FAIL read_addr1: got %h expected 06", rd_addr[r0 + 1]); end
        for (int i = r0; i < rd_n; i++) if (rd_addr[i] == 7'h05) n5++;
        checks++;
        if (n5 !== 1) begin errors++; $display("FAIL read_single_at_05: got %0d expected 1", n5); end
        checks++;
        if (wr_n - w0 !== 0) begin errors++; $display("FAIL read_no_write: got %0d expected 0", wr_n - w0); end
    endtask

    task automatic test_burst_write();
        logic [127:0] r;
        int w0 = wr_n;
        logic [6:0] ea [0:2];
        logic [7:0] ed [0:2];
        ea[0] = 7'h7E; ea[1] = 7'h7F; ea[2] = 7'h00;
        ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
        spi_xfer(1'b0, 32, {1'b1, 7'h7E, 8'h11, 8'h22, 8'h33}, r);
        checks++;
        if (wr_n - w0 !== 3) begin errors++; $display("FAIL burst_count: got %0d expected 3", wr_n - w0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_addr[w0 + i] !== ea[i] || wr_data[w0 + i] !== ed[i]) begin
                errors++;
                $display("FAIL burst_word%0d: got %h/%h expected %h/%h", i, wr_addr[w0 + i], wr_data[w0 + i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_frame_err();
        logic [127:0] r;
        int w0 = wr_n, f0 = ferr_n;
        spi_xfer(1'b0, 10, {1'b1, 7'h40, 2'b10}, r);
        checks++;
        if (wr_n - w0 !== 0) begin errors++; $display("FAIL ferr_no_write: got %0d expected 0", wr_n - w0); end
        checks++;
        if (ferr_n - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_n - f0); end
        w0 = wr_n;
        spi_xfer(1'b0, 16, {1'b1, 7'h01, 8'hFF}, r);
        checks++;
        if (wr_n - w0 !== 1 || wr_addr[w0] !== 7'h01 || wr_data[w0] !== 8'hFF) begin
            errors++;
            $display("FAIL ferr_recover: got n=%0d %h/%h expected n=1 01/ff", wr_n - w0, wr_addr[w0], wr_data[w0]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [127:0] r;
        logic [15:0] fr = {1'b1, 7'h20, 8'h5A};
        logic m;
        int w0 = wr_n, f0 = ferr_n;
        spi_begin(1'b0);
        for (int i = 0; i < 12; i++) spi_bit(fr[15 - i], m);
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b expected 1", a_busy); end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_wr, a_rd, a_ferr, a_busy, a_miso, a_addr, a_wdata} !== 20'h0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %h expected 0", {a_wr, a_rd, a_ferr, a_busy, a_miso, a_addr, a_wdata});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 12; i < 16; i++) spi_bit(fr[15 - i], m);
        spi_end();
        checks++;
        if (wr_n - w0 !== 0 || ferr_n - f0 !== 0) begin
            errors++;
            $display("FAIL midframe_aborted: got wr=%0d ferr=%0d expected 0/0", wr_n - w0, ferr_n - f0);
        end
        spi_xfer(1'b0, 16, {1'b1, 7'h33, 8'h99}, r);
        checks++;
        if (wr_n - w0 !== 1 || wr_addr[w0] !== 7'h33 || wr_data[w0] !== 8'h99) begin
            errors++;
            $display("FAIL midframe_next_frame: got n=%0d %h/%h expected n=1 33/99", wr_n - w0, wr_addr[w0], wr_data[w0]);
        end
    endtask

    task automatic test_no_burst_wide();
        logic [127:0] r;
        int w0 = b_wr_n, f0 = b_ferr_n, a0 = wr_n;
        spi_xfer(1'b1, 69, {1'b1, 4'h3, 32'hDEADBEEF, 32'h12345678}, r);
        checks++;
        if (b_wr_n - w0 !== 1) begin errors++; $display("FAIL wide_count: got %0d expected 1", b_wr_n - w0); end
        checks++;
        if (b_wr_addr[w0] !== 4'h3) begin errors++; $display("FAIL wide_addr: got %h expected 3", b_wr_addr[w0]); end
        checks++;
        if (b_wr_data[w0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wide_data: got %h expected deadbeef", b_wr_data[w0]); end
        checks++;
        if (b_ferr_n - f0 !== 0 || wr_n - a0 !== 0) begin
            errors++;
            $display("FAIL wide_isolation: got ferr=%0d other_wr=%0d expected 0/0", b_ferr_n - f0, wr_n - a0);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_n !== 0) begin errors++; $display("FAIL wr_rd_exclusive: got %0d overlapping cycles expected 0", both_n); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst_write();
        test_frame_err();
        test_reset_midframe();
        test_no_burst_wide();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_regbank_slave.md
Name: spi_regbank_slave

Overview:
- Parametrised SPI slave front-end that turns SPI frames into single-cycle register read/write strobes in the i_clk domain.
- Successor to the fixed 7-bit-address / 8-bit-data SPI register port on the SHA-256 core.
- Adds configurable address and data widths, burst mode with address auto-increment, framing-error reporting, and pipelined readback.
- Sits between the external SPI master and any core register bank (message buffer, status/control, digest).

Parameters:
- ADDR_W, 7, register address width in bits.
- DATA_W, 8, data word width in bits.
- BURST_EN, 1, 1 = additional words in the same SS_n window go to auto-incremented addresses; 0 = every word after the first is ignored.
- SYNC_STAGES, 2, synchroniser depth for i_sck, i_ss_n and i_spi_mosi.

Ports:
- i_clk  in  1  system clock; must run at least 10× the SCK frequency.
- i_rst  in  1  asynchronous, active-high reset.
- i_sck  in  1  SPI clock, idles high (mode 3).
- i_ss_n  in  1  SPI slave select, active low.
- i_spi_mosi  in  1  master data, changes on SCK falling edge, MSB first.
- o_spi_miso  out  1  slave data, changes on SCK falling edge, MSB first.
- o_reg_wr_en  out  1  one-cycle write strobe.
- o_reg_rd_en  out  1  one-cycle read request.
- o_reg_addr  out  ADDR_W  register address for the current strobe.
- o_reg_wdata  out  DATA_W  write data; valid while o_reg_wr_en is high.
- i_reg_rdata  in  DATA_W  read data; valid exactly 1 cycle after o_reg_rd_en.
- o_frame_err  out  1  one-cycle pulse when SS_n rises mid-word.
- o_busy  out  1  high while SS_n is asserted and a frame is in progress.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Shift registers and bit counter cleared.
- Reset asserted mid-frame aborts the frame with no strobe and no o_frame_err. The slave waits for the next SS_n falling edge.
- SCK, SS_n and MOSI pass through SYNC_STAGES flops before use. Edge detect runs on the synchronised SCK. MOSI is sampled on the detected rising edge.
- Frame format: header of 1+ADDR_W bits = {n_r_w, addr}, n_r_w = 1 means write. Header is followed by one or more DATA_W-bit words.
- IDLE: wait for SS_n falling edge, then go to HDR with the bit counter cleared.
- HDR: shift in 1+ADDR_W bits. On the last bit, latch the address and direction.
  - Write: go to WDATA.
  - Read: pulse o_reg_rd_en with o_reg_addr = addr on the next i_clk cycle, capture i_reg_rdata 1 cycle later into the TX shift register, then go to RDATA.
- WDATA: shift in DATA_W bits. On the last rising edge, o_reg_wr_en pulses within 2 i_clk cycles, with o_reg_addr and o_reg_wdata held stable for that cycle.
- RDATA: MISO drives the TX shift register MSB. The register shifts on each detected SCK falling edge.
  - The first data bit is valid before the first data rising edge; this is guaranteed by the 10× clock ratio.
  - On the last rising edge of a read word with BURST_EN = 1, issue the next o_reg_rd_en for addr+1.
- Burst: after each completed word with BURST_EN = 1, the address increments by 1, modulo 2^ADDR_W (0x7F wraps to 0x00 at default width). The direction is fixed by the header.
- With BURST_EN = 0, further words are shifted but produce no strobes.
- o_spi_miso is 0 during HDR, during IDLE, and while SS_n is high. There is no tristate; the pad handles that.
- SS_n rise exactly at a word/header boundary: return to IDLE silently.
- SS_n rise with the bit counter not 0 (partial header or word): discard the partial data, no strobe, pulse o_frame_err for 1 cycle, return to IDLE.
- o_busy is high from SS_n fall (synchronised) to return to IDLE.
- o_reg_wr_en and o_reg_rd_en are never high in the same cycle.

Test Plan:
- Default params, write frame {1, 0x12, 0xA5} → exactly one o_reg_wr_en, o_reg_addr = 0x12, o_reg_wdata = 0xA5. o_frame_err stays 0.
- Read frame {0, 0x05} with bank returning 0x3C → one o_reg_rd_en at addr 0x05. Bench captures miso bits 9–16 on SCK rising edges = 0x3C. Bits 1–8 = 0.
- Burst write starting at 0x7E with data 0x11, 0x22, 0x33 in one SS_n window → three strobes at addr 0x7E/0x11, 0x7F/0x22, 0x00/0x33.
- SS_n raised after 10 SCK cycles of a write → no o_reg_wr_en, one o_frame_err pulse. A following full frame {1, 0x01, 0xFF} is accepted normally.
- i_rst pulsed mid-WDATA → all outputs return to 0 immediately. No strobe from the aborted frame. The next frame works.
- ADDR_W = 4, DATA_W = 32, BURST_EN = 0: write {1, 0x3, 0xDEADBEEF} followed by a second word in the same window → a single strobe at addr 0x3 with data 0xDEADBEEF. The second word is ignored.
